// File: rtl/bank_resp_adapter_pkg.sv
// Shared helpers for the bank response adapter.
package bank_resp_adapter_pkg;

  // Width of an index into n items, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tracker_fifo.sv
// Small synchronous FIFO: registered push/pop, head visible on rdata_o, no fall-through.
module tracker_fifo #(
  parameter int Width = 8,
  parameter int Depth = 4,
  localparam int AW = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int UW = $clog2(Depth + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [UW-1:0]    usage_o
);

  logic [Width-1:0] r_mem [Depth];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [UW-1:0]    r_usage;

  // Pointers wrap naturally because Depth is a power of two.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_usage <= '0;
    end else begin
      if (push_i) r_wptr <= r_wptr + AW'(1);
      if (pop_i)  r_rptr <= r_rptr + AW'(1);
      if (push_i && !pop_i)      r_usage <= r_usage + UW'(1);
      else if (!push_i && pop_i) r_usage <= r_usage - UW'(1);
    end
  end

  // Storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (push_i) r_mem[r_wptr] <= wdata_i;
  end

  assign rdata_o = r_mem[r_rptr];
  assign full_o  = (r_usage == UW'(Depth));
  assign empty_o = (r_usage == '0);
  assign usage_o = r_usage;

endmodule

// File: rtl/bank_resp_adapter.sv
// Target-port endpoint: forwards requests to a memory bank, tags in-order read
// data with the issuing initiator, and limits in-flight work with a credit count.
module bank_resp_adapter
  import bank_resp_adapter_pkg::*;
#(
  parameter int NumIn          = 4,
  parameter int DataWidth      = 32,
  parameter int MaxOutstanding = 4,
  localparam int IdxW = idx_width(NumIn),
  localparam int CntW = $clog2(MaxOutstanding + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [IdxW-1:0]      req_ini_addr_i,
  input  logic [DataWidth-1:0] req_wdata_i,
  output logic                 bank_req_o,
  input  logic                 bank_gnt_i,
  output logic [DataWidth-1:0] bank_wdata_o,
  input  logic                 bank_rvalid_i,
  input  logic [DataWidth-1:0] bank_rdata_i,
  output logic                 resp_valid_o,
  input  logic                 resp_ready_i,
  output logic [IdxW-1:0]      resp_ini_addr_o,
  output logic [DataWidth-1:0] resp_rdata_o,
  output logic [CntW-1:0]      outstanding_o
);

  localparam logic [CntW-1:0] MaxCnt = CntW'(MaxOutstanding);

  logic [CntW-1:0] r_cnt;
  logic            w_credit;
  logic            w_req_hs;
  logic            w_resp_hs;
  logic            w_id_full;
  logic            w_id_empty;
  logic            w_data_full;
  logic            w_data_empty;
  logic [CntW-1:0] w_id_usage;
  logic [CntW-1:0] w_data_usage;

  // The credit check uses only the registered count, so a credit freed by a
  // response this cycle is not reusable until the next one. Reset blocks issue.
  assign w_credit     = (r_cnt < MaxCnt) && !rst_i;
  assign bank_req_o   = req_valid_i && w_credit;
  assign req_ready_o  = bank_gnt_i && w_credit;
  assign bank_wdata_o = req_wdata_i;

  assign w_req_hs     = req_valid_i && req_ready_o;
  assign w_resp_hs    = resp_valid_o && resp_ready_i;
  assign resp_valid_o = !w_data_empty;
  assign outstanding_o = r_cnt;

  // Credit counter: +1 per accepted request, -1 per delivered response.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (w_req_hs && !w_resp_hs) begin
      r_cnt <= r_cnt + CntW'(1);
    end else if (!w_req_hs && w_resp_hs) begin
      r_cnt <= r_cnt - CntW'(1);
    end
  end

  tracker_fifo #(
    .Width (IdxW),
    .Depth (MaxOutstanding)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_req_hs),
    .wdata_i (req_ini_addr_i),
    .pop_i   (w_resp_hs),
    .rdata_o (resp_ini_addr_o),
    .full_o  (w_id_full),
    .empty_o (w_id_empty),
    .usage_o (w_id_usage)
  );

  // Bank responses cannot be stalled; the credit limit leaves room for them.
  tracker_fifo #(
    .Width (DataWidth),
    .Depth (MaxOutstanding)
  ) u_data_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (bank_rvalid_i),
    .wdata_i (bank_rdata_i),
    .pop_i   (w_resp_hs),
    .rdata_o (resp_rdata_o),
    .full_o  (w_data_full),
    .empty_o (w_data_empty),
    .usage_o (w_data_usage)
  );

  // Catch bank misbehaviour: orphan responses, data overflow, FIFOs out of step.
  always @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(bank_rvalid_i && (w_id_usage <= w_data_usage)));
      assert (!(bank_rvalid_i && w_data_full));
      assert (!(w_req_hs && w_id_full));
      assert (!(w_resp_hs && w_id_empty));
    end
  end

endmodule

// File: doc/bank_resp_adapter.md
Name: bank_resp_adapter

Overview:
- Responder-side endpoint placed on each target port of the request crossbar.
- Passes arbitrated requests (data + initiator index) to a variable-latency memory bank.
- Records the initiator index of every issued request and pairs it, in order, with the bank's read data.
- Presents each tagged response on a valid/ready port toward the response crossbar, bounding in-flight transactions with a credit counter.

Parameters:
- NumIn, 4, number of initiators; index width IdxW = $clog2(NumIn), minimum 1.
- DataWidth, 32, request and response data width.
- MaxOutstanding, 4, maximum issued-but-not-delivered transactions; power of two, at least 2; also the depth of both internal FIFOs.

Ports:
- clk_i  in  1  clock; single clock domain.
- rst_i  in  1  reset; asynchronous, active-high.
- req_valid_i  in  1  request valid from the crossbar target side.
- req_ready_o  out  1  request accepted.
- req_ini_addr_i  in  IdxW  initiator index of the request.
- req_wdata_i  in  DataWidth  request payload.
- bank_req_o  out  1  request to the bank.
- bank_gnt_i  in  1  bank accepts the request.
- bank_wdata_o  out  DataWidth  payload to the bank; equals req_wdata_i.
- bank_rvalid_i  in  1  bank response valid; in order, cannot be backpressured.
- bank_rdata_i  in  DataWidth  bank response data.
- resp_valid_o  out  1  response valid toward the response crossbar.
- resp_ready_i  in  1  response accepted.
- resp_ini_addr_o  out  IdxW  destination initiator of the response.
- resp_rdata_o  out  DataWidth  response data.
- outstanding_o  out  $clog2(MaxOutstanding+1)  current credit count.

Behaviour:
- Credit counter cnt:
  - Increments on a request handshake (req_valid_i && req_ready_o).
  - Decrements on a response handshake (resp_valid_o && resp_ready_i).
  - Both in the same cycle: unchanged.
  - outstanding_o = cnt.
- Request path is combinational, zero latency:
  - bank_req_o = req_valid_i && (cnt < MaxOutstanding).
  - req_ready_o = bank_gnt_i && (cnt < MaxOutstanding).
  - At cnt == MaxOutstanding, bank_req_o = 0 and req_ready_o = 0, even if a response pops in the same cycle. A credit freed this cycle is usable next cycle.
  - bank_req_o must not depend on bank_gnt_i.
- ID FIFO (IdxW wide):
  - Push req_ini_addr_i on a request handshake.
  - Pop on a response handshake.
- Data FIFO (DataWidth wide):
  - Push bank_rdata_i whenever bank_rvalid_i = 1.
  - Pop on a response handshake.
  - The credit limit guarantees it never overflows.
- Response output:
  - resp_valid_o = data FIFO not empty.
  - resp_rdata_o = data FIFO head; resp_ini_addr_o = ID FIFO head.
  - Minimum latency: resp_valid_o rises the cycle after bank_rvalid_i.
  - Data and index stay stable while resp_valid_o && !resp_ready_i (AXI-style valid/ready: valid never retracts before the handshake).
- Bank timing: bank_rvalid_i arrives at least 1 cycle after the granting cycle.
- Error conditions (simulation assertions, no recovery):
  - bank_rvalid_i while the ID FIFO holds no entry without data.
  - Data FIFO push while full.
- Simultaneous push and pop on either FIFO in the same cycle: both take effect; occupancy unchanged; pointers wrap modulo MaxOutstanding.
- Reset (asynchronous, takes effect immediately, also mid-operation):
  - cnt = 0, both FIFOs empty, resp_valid_o = 0, bank_req_o = 0, req_ready_o = 0 while rst_i is high.
  - All in-flight transactions are discarded; bank_rvalid_i during reset is ignored.
  - Integration requirement: the bank must not return responses for pre-reset requests.
- resp_ini_addr_o and resp_rdata_o are don't-care while resp_valid_o = 0.

Decomposition:
- Shared package holds no typedefs.
- IdxW and the count width are local parameters derived from the module parameters.
- One sub-module: tracker_fifo.
  - Parameters: Width, Depth.
  - Synchronous push/pop, no fall-through.
  - Outputs: full, empty, usage.
  - Asynchronous active-high reset.
  - Instantiated twice: ID FIFO and data FIFO.

Test Plan:
1. Single request, initiator 2, wdata 0xDEADBEEF, bank_gnt_i=1, bank_rvalid_i 3 cycles later with rdata 0x12345678 -> bank_wdata_o=0xDEADBEEF in the accept cycle; resp_valid_o one cycle after rvalid with ini_addr 2 and rdata 0x12345678; outstanding_o 0->1->0.
2. MaxOutstanding=4, requests from initiators 0,1,2,3,1 back-to-back, resp_ready_i=0, bank returns 0xA0..0xA3 -> 5th request stalls (req_ready_o=0, bank_req_o=0) at outstanding_o=4; after resp_ready_i=1, responses emerge (0,0xA0),(1,0xA1),(2,0xA2),(3,0xA3), then the 5th request is accepted.
3. cnt=3, same-cycle request handshake and response handshake -> outstanding_o stays 3; both FIFO occupancies are correct next cycle.
4. req_valid_i=1, bank_gnt_i=0 for 5 cycles -> bank_req_o=1, req_ready_o=0, outstanding_o stays 0, no FIFO push.
5. resp_ready_i low for 10 cycles with a response pending -> resp_valid_o held 1; resp_ini_addr_o and resp_rdata_o are stable and unchanged.
6. rst_i asserted asynchronously with 3 outstanding and 1 response pending -> resp_valid_o and outstanding_o go to 0 immediately; after release, a new request from initiator 1 completes normally.
